// File: rtl/mpd_pad_cfg_loader.sv
// Bit-bang serial loader that checks a header and an exact bit count, then commits pad configuration atomically.
// Optional feature MPD_CFG_READBACK_EN adds o_sdout, which shifts out the current configuration during the payload.
module mpd_pad_cfg_loader #(
    parameter int NUM_PADS    = 44,
    parameter int CFG_BITS    = 13,
    parameter int SYNC_STAGES = 2,
    parameter logic [15:0] HEADER = 16'hFAB5,
    parameter logic [NUM_PADS*CFG_BITS-1:0] CFG_DEFAULT = {(NUM_PADS*CFG_BITS){1'b0}}
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_sclk,
    input  logic                           i_sdata,
    input  logic                           i_sel,
    output logic [NUM_PADS*CFG_BITS-1:0]   o_pad_cfg,
    output logic                           o_cfg_valid,
    output logic                           o_cfg_err,
`ifdef MPD_CFG_READBACK_EN
    output logic                           o_sdout,
`endif
    output logic                           o_busy
);

    localparam int CFG_W      = NUM_PADS * CFG_BITS;
    localparam int FRAME_BITS = 16 + CFG_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int WARM_W     = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0]  HDR_LAST  = CNT_W'(15);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_FULL    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    state_t                   state_r;
    logic [SYNC_STAGES-1:0]   sclk_sync_r;
    logic [SYNC_STAGES-1:0]   sdata_sync_r;
    logic [SYNC_STAGES-1:0]   sel_sync_r;
    logic                     sclk_d_r;
    logic                     sdata_d_r;
    logic                     sel_d_r;
    logic [WARM_W-1:0]        warm_cnt_r;
    logic                     sclk_rise_r;
    logic                     sel_rise_r;
    logic                     sel_fall_r;
    logic                     sclk_rise_s;
    logic                     sel_rise_s;
    logic                     sel_fall_s;
    logic [CNT_W-1:0]         bit_cnt_r;
    logic [CNT_W-1:0]         cnt_inc_s;
    logic [14:0]              hdr_r;
    logic [CFG_W-1:0]         shadow_r;
    logic                     shadow_shift_s;

    // Synchronise the bit-bang inputs and keep one delayed copy of each for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sclk_sync_r  <= {SYNC_STAGES{1'b0}};
            sdata_sync_r <= {SYNC_STAGES{1'b0}};
            sel_sync_r   <= {SYNC_STAGES{1'b0}};
            sclk_d_r     <= 1'b0;
            sdata_d_r    <= 1'b0;
            sel_d_r      <= 1'b0;
        end else begin
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], i_sclk};
            sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], i_sdata};
            sel_sync_r   <= {sel_sync_r[SYNC_STAGES-2:0], i_sel};
            sclk_d_r     <= sclk_sync_r[SYNC_STAGES-1];
            sdata_d_r    <= sdata_sync_r[SYNC_STAGES-1];
            sel_d_r      <= sel_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_d_r;
    assign sel_rise_s  = sel_sync_r[SYNC_STAGES-1] & ~sel_d_r;
    assign sel_fall_s  = ~sel_sync_r[SYNC_STAGES-1] & sel_d_r;

    // Register edge pulses; masked until the pipeline has refilled after reset, so a sel held high cannot open a frame
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            warm_cnt_r  <= {WARM_W{1'b0}};
            sclk_rise_r <= 1'b0;
            sel_rise_r  <= 1'b0;
            sel_fall_r  <= 1'b0;
        end else if (warm_cnt_r != WARM_DONE) begin
            warm_cnt_r  <= warm_cnt_r + WARM_W'(1);
            sclk_rise_r <= 1'b0;
            sel_rise_r  <= 1'b0;
            sel_fall_r  <= 1'b0;
        end else begin
            warm_cnt_r  <= warm_cnt_r;
            sclk_rise_r <= sclk_rise_s;
            sel_rise_r  <= sel_rise_s;
            sel_fall_r  <= sel_fall_s;
        end
    end

    // Saturating increment of the frame bit counter
    always_comb begin
        cnt_inc_s = bit_cnt_r;
        if (bit_cnt_r == FRAME_CNT) begin
            cnt_inc_s = bit_cnt_r;
        end else begin
            cnt_inc_s = bit_cnt_r + CNT_W'(1);
        end
    end

    // A sel fall in the same cycle wins over an sclk edge, so the shadow only shifts without one
    assign shadow_shift_s = (state_r == ST_PAYLOAD) & sclk_rise_r & ~sel_fall_r;

    // Payload shadow register; only its contents at commit time matter
    always_ff @(posedge i_clk) begin
        if (shadow_shift_s) begin
            shadow_r <= {shadow_r[CFG_W-2:0], sdata_d_r};
        end else begin
            shadow_r <= shadow_r;
        end
    end

`ifdef MPD_CFG_READBACK_EN
    logic [CNT_W-1:0] rb_idx_s;
    // Bit of the current configuration presented after this payload edge
    assign rb_idx_s = FRAME_CNT - CNT_W'(2) - bit_cnt_r;
`endif

    // Frame state machine with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {CNT_W{1'b0}};
            hdr_r       <= 15'h0000;
            o_pad_cfg   <= CFG_DEFAULT;
            o_cfg_valid <= 1'b0;
            o_cfg_err   <= 1'b0;
            o_busy      <= 1'b0;
`ifdef MPD_CFG_READBACK_EN
            o_sdout     <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_rise_r) begin
                        bit_cnt_r <= {CNT_W{1'b0}};
                        o_cfg_err <= 1'b0;
                        o_busy    <= 1'b1;
                        state_r   <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (sel_fall_r) begin
                        o_cfg_err <= 1'b1;
                        o_busy    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (sclk_rise_r) begin
                        hdr_r     <= {hdr_r[13:0], sdata_d_r};
                        bit_cnt_r <= cnt_inc_s;
                        if (bit_cnt_r == HDR_LAST) begin
                            if ({hdr_r, sdata_d_r} == HEADER) begin
                                state_r <= ST_PAYLOAD;
`ifdef MPD_CFG_READBACK_EN
                                o_sdout <= o_pad_cfg[CFG_W-1];
`endif
                            end else begin
                                o_busy  <= 1'b0;
                                state_r <= ST_ERROR;
                            end
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (sel_fall_r) begin
                        o_cfg_err <= 1'b1;
                        o_busy    <= 1'b0;
                        state_r   <= ST_IDLE;
`ifdef MPD_CFG_READBACK_EN
                        o_sdout   <= 1'b0;
`endif
                    end else if (sclk_rise_r) begin
                        bit_cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == FRAME_CNT) begin
                            o_busy  <= 1'b0;
                            state_r <= ST_FULL;
`ifdef MPD_CFG_READBACK_EN
                            o_sdout <= 1'b0;
`endif
                        end else begin
`ifdef MPD_CFG_READBACK_EN
                            o_sdout <= o_pad_cfg[rb_idx_s];
`endif
                        end
                    end
                end
                ST_FULL: begin
                    if (sel_fall_r) begin
                        o_pad_cfg   <= shadow_r;
                        o_cfg_valid <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else if (sclk_rise_r) begin
                        state_r <= ST_ERROR;
                    end
                end
                ST_ERROR: begin
                    if (sel_fall_r) begin
                        o_cfg_err <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpd_pad_cfg_loader.sv
// Directed self-checking bench for mpd_pad_cfg_loader (readback checks active when MPD_CFG_READBACK_EN is defined).
module tb_mpd_pad_cfg_loader;

    localparam int W = 572;

    logic         clk;
    logic         i_reset;
    logic         i_sclk;
    logic         i_sdata;
    logic         i_sel;
    logic [W-1:0] o_pad_cfg;
    logic         o_cfg_valid;
    logic         o_cfg_err;
    logic         o_busy;
`ifdef MPD_CFG_READBACK_EN
    logic         o_sdout;
`endif

    int checks = 0;
    int errors = 0;
    int rb_bad = 0;
    logic [W-1:0] pay1, pay2, pay3, model_cfg;
    logic [W-1:0] zero_cfg;

    mpd_pad_cfg_loader dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_sclk     (i_sclk),
        .i_sdata    (i_sdata),
        .i_sel      (i_sel),
        .o_pad_cfg  (o_pad_cfg),
        .o_cfg_valid(o_cfg_valid),
        .o_cfg_err  (o_cfg_err),
`ifdef MPD_CFG_READBACK_EN
        .o_sdout    (o_sdout),
`endif
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Shift n bits MSB first; bits beyond the 588-bit frame are zeros. Readback is sampled before each payload rise.
    task automatic send_bits(input logic [W+15:0] frame, input int n);
        for (int i = 0; i < n; i++) begin
            i_sdata = (i < W + 16) ? frame[W + 15 - i] : 1'b0;
            tick(4);
`ifdef MPD_CFG_READBACK_EN
            if (i >= 16 && i < W + 16) begin
                if (o_sdout !== model_cfg[W - 1 - (i - 16)]) rb_bad++;
            end
`endif
            i_sclk = 1'b1;
            tick(4);
            i_sclk = 1'b0;
        end
    endtask

    task automatic open_frame();
        i_sel = 1'b1;
        tick(6);
    endtask

    task automatic close_frame();
        i_sel = 1'b0;
        tick(6);
    endtask

    initial begin
        zero_cfg = {W{1'b0}};
        for (int p = 0; p < 44; p++) begin
            pay1[p*13 +: 13] = 13'(p * 37 + 5);
            pay2[p*13 +: 13] = ~13'(p * 101 + 3);
            pay3[p*13 +: 13] = 13'(p * p * 7 + 1000) ^ 13'h1555;
        end
        model_cfg = zero_cfg;
        i_reset = 1'b1;
        i_sclk  = 1'b0;
        i_sdata = 1'b0;
        i_sel   = 1'b0;
        tick(2);
        i_reset = 1'b0;
        tick(1);

        check("reset_cfg", o_pad_cfg, zero_cfg);
        check("reset_valid", o_cfg_valid, 1'b0);
        check("reset_err", o_cfg_err, 1'b0);
        check("reset_busy", o_busy, 1'b0);

        // Good frame: commit lands exactly 4 edges after the sel fall
        open_frame();
        check("open_busy", o_busy, 1'b1);
        rb_bad = 0;
        send_bits({16'hFAB5, pay1}, 588);
        i_sel = 1'b0;
        tick(3);
        check("valid_early", o_cfg_valid, 1'b0);
        check("cfg_early", o_pad_cfg, zero_cfg);
        tick(1);
        check("valid_edge4", o_cfg_valid, 1'b1);
        check("good1_cfg", o_pad_cfg, pay1);
        check("good1_err", o_cfg_err, 1'b0);
        check("good1_busy", o_busy, 1'b0);
`ifdef MPD_CFG_READBACK_EN
        check("good1_readback", 32'(rb_bad), 32'd0);
`endif
        model_cfg = pay1;
        tick(4);

        // Bad header
        open_frame();
        send_bits({16'hFAB4, pay2}, 588);
        check("badhdr_busy", o_busy, 1'b0);
        close_frame();
        check("badhdr_err", o_cfg_err, 1'b1);
        check("badhdr_cfg", o_pad_cfg, pay1);
        check("badhdr_valid", o_cfg_valid, 1'b1);

        // Underrun
        open_frame();
        check("under_errclr", o_cfg_err, 1'b0);
        send_bits({16'hFAB5, pay2}, 587);
        check("under_busy", o_busy, 1'b1);
        close_frame();
        check("under_err", o_cfg_err, 1'b1);
        check("under_cfg", o_pad_cfg, pay1);

        // Overrun
        open_frame();
        check("over_errclr", o_cfg_err, 1'b0);
        send_bits({16'hFAB5, pay2}, 589);
        close_frame();
        check("over_err", o_cfg_err, 1'b1);
        check("over_cfg", o_pad_cfg, pay1);

        // Good frame after errors
        open_frame();
        check("good2_errclr", o_cfg_err, 1'b0);
        rb_bad = 0;
        send_bits({16'hFAB5, pay2}, 588);
        close_frame();
        check("good2_cfg", o_pad_cfg, pay2);
        check("good2_err", o_cfg_err, 1'b0);
`ifdef MPD_CFG_READBACK_EN
        check("good2_readback", 32'(rb_bad), 32'd0);
`endif
        model_cfg = pay2;

        // Extra sclk rise coincident with the sel fall
        open_frame();
        send_bits({16'hFAB5, pay3}, 588);
        i_sclk = 1'b1;
        i_sel  = 1'b0;
        tick(8);
        i_sclk = 1'b0;
        tick(2);
        check("simul_cfg", o_pad_cfg, pay3);
        check("simul_err", o_cfg_err, 1'b0);
        check("simul_valid", o_cfg_valid, 1'b1);
        model_cfg = pay3;

        // Reset mid-frame with sel held high
        open_frame();
        send_bits({16'hFAB5, pay1}, 300);
        check("mid_busy", o_busy, 1'b1);
        i_reset = 1'b1;
        tick(1);
        i_reset = 1'b0;
        check("mid_rst_cfg", o_pad_cfg, zero_cfg);
        check("mid_rst_valid", o_cfg_valid, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        model_cfg = zero_cfg;
        tick(6);
        send_bits({16'hFAB5, pay1}, 40);
        check("held_sel_idle", o_busy, 1'b0);
        close_frame();
        open_frame();
        check("reopen_busy", o_busy, 1'b1);
        rb_bad = 0;
        send_bits({16'hFAB5, pay1}, 588);
        close_frame();
        check("post_rst_cfg", o_pad_cfg, pay1);
        check("post_rst_valid", o_cfg_valid, 1'b1);
        check("post_rst_err", o_cfg_err, 1'b0);
`ifdef MPD_CFG_READBACK_EN
        check("post_rst_readback", 32'(rb_bad), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
